stream_slice_deser: RTL and testbench

- Sequential deserializer (stream unpacker) that is the receiving end of a slice-serialized word stream.
- Accepts SLICE-bit chunks on a valid/ready input, reassembles them into an XLEN-bit word, and presents the word on a valid/ready output.
- Slice ordering and in-slice bit order are configurable, so the block reconstructs words produced by left- or right-streaming (`{<<SLICE{}}` / `{>>SLICE{}}`) serializers.
- Used wherever packed words are sent serially and must be rebuilt, including bit-reversed (SLICE=1) paths.

---
 rtl/stream_slice_deser.sv | 106 ++++++++++
 tb/tb_stream_slice_deser.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_slice_deser.sv
// stream_slice_deser: rebuilds XLEN-bit words from SLICE-bit chunks that
// arrive on a valid/ready stream. Slot order and in-chunk bit order are
// selectable so both left- and right-streamed serializers can be undone.
// A chunk flagged in_last closes the word early; unwritten slots read 0.
module stream_slice_deser #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned SLICE     = 8,
   parameter int unsigned MSB_FIRST = 0,
   parameter int unsigned BIT_REV   = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [SLICE-1:0]                     in_data,
   input  logic                                 in_last,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [XLEN-1:0]                      out_data,
   output logic [$clog2(XLEN/SLICE+1)-1:0]      out_count,
   output logic                                 out_last
);

   localparam int unsigned N  = XLEN / SLICE;
   localparam int unsigned CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);

   logic [XLEN-1:0]  acc_r;
   logic [CW-1:0]    cnt_r;
   logic [SLICE-1:0] chunk_s;
   logic [CW-1:0]    slot_s;
   logic [XLEN-1:0]  merged_s;
   logic             accept_s;
   logic             complete_s;
   logic             out_hs_s;

   // Mirror the bit order of one chunk (LSB becomes MSB)
   function automatic logic [SLICE-1:0] reverse_slice(input logic [SLICE-1:0] d);
      logic [SLICE-1:0] r;
      for (int b = 0; b < int'(SLICE); b++) begin
         r[b] = d[int'(SLICE) - 1 - b];
      end
      return r;
   endfunction

   // The output register frees up either when empty or when it drains this cycle
   assign in_ready   = !out_valid || out_ready;
   assign accept_s   = in_valid && in_ready;
   assign out_hs_s   = out_valid && out_ready;
   assign complete_s = accept_s && ((cnt_r == LAST_SLOT) || in_last);

   // Transform the incoming chunk and merge it into its slot of the accumulator
   always_comb begin
      chunk_s  = in_data;
      slot_s   = cnt_r;
      merged_s = acc_r;
      if (BIT_REV != 0) begin
         chunk_s = reverse_slice(in_data);
      end else begin
         chunk_s = in_data;
      end
      if (MSB_FIRST != 0) begin
         slot_s = LAST_SLOT - cnt_r;
      end else begin
         slot_s = cnt_r;
      end
      for (int k = 0; k < int'(N); k++) begin
         if (slot_s == CW'(k)) begin
            merged_s[k*SLICE +: SLICE] = chunk_s;
         end else begin
            merged_s[k*SLICE +: SLICE] = acc_r[k*SLICE +: SLICE];
         end
      end
   end

   // Accumulate chunks, publish finished words and retire them on handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r     <= '0;
         cnt_r     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_last  <= 1'b0;
      end else if (accept_s) begin
         if (complete_s) begin
            // A new word replaces the old one even if it drains this cycle
            out_data  <= merged_s;
            out_count <= cnt_r + CW'(1);
            out_last  <= in_last;
            out_valid <= 1'b1;
            acc_r     <= '0;
            cnt_r     <= '0;
         end else begin
            acc_r <= merged_s;
            cnt_r <= cnt_r + CW'(1);
            if (out_hs_s) begin
               out_valid <= 1'b0;
            end
         end
      end else if (out_hs_s) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_slice_deser.sv
// Bench for stream_slice_deser: four configurations share one chunk stream
// (8-bit LSB-first, 8-bit MSB-first, 1-bit, 8-bit bit-reversed) and each is
// compared every cycle against a word-level reference model.
module tb_stream_slice_deser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;

   logic        rdy [4];
   logic        ov  [4];
   logic        ol  [4];
   logic [31:0] od  [4];
   logic [5:0]  oc  [4];
   logic [2:0]  cnt_a, cnt_b, cnt_d;
   logic [5:0]  cnt_c;

   int n_vec = 0;
   int n_err = 0;

   // reference model state, one entry per instance
   bit          m_valid [4];
   logic [31:0] m_data  [4];
   int          m_count [4];
   bit          m_last  [4];
   int          m_nb    [4];
   logic [7:0]  m_buf   [4][32];

   always #5 clk = ~clk;

   stream_slice_deser #(.XLEN(32), .SLICE(8), .MSB_FIRST(0), .BIT_REV(0)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
      .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
      .out_count(cnt_a), .out_last(ol[0]));
   stream_slice_deser #(.XLEN(32), .SLICE(8), .MSB_FIRST(1), .BIT_REV(0)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
      .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
      .out_count(cnt_b), .out_last(ol[1]));
   stream_slice_deser #(.XLEN(32), .SLICE(1), .MSB_FIRST(0), .BIT_REV(0)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data[0:0]),
      .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
      .out_count(cnt_c), .out_last(ol[2]));
   stream_slice_deser #(.XLEN(32), .SLICE(8), .MSB_FIRST(0), .BIT_REV(1)) u_d (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
      .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]),
      .out_count(cnt_d), .out_last(ol[3]));

   assign oc[0] = {3'b000, cnt_a};
   assign oc[1] = {3'b000, cnt_b};
   assign oc[2] = cnt_c;
   assign oc[3] = {3'b000, cnt_d};

   function automatic int sl_of(int i);
      return (i == 2) ? 1 : 8;
   endfunction

   // count one comparison and report it when it differs
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // assemble the collected chunks of instance i with plain shift arithmetic
   function automatic logic [31:0] build_word(int i);
      int          sl;
      int          n;
      int          pos;
      logic [31:0] w;
      logic [7:0]  c;
      logic [7:0]  r;
      sl = sl_of(i);
      n  = 32 / sl;
      w  = 32'h0;
      for (int k = 0; k < m_nb[i]; k++) begin
         c = m_buf[i][k];
         r = 8'h00;
         if (i == 3) begin
            for (int b = 0; b < sl; b++) r[sl-1-b] = c[b];
         end else begin
            r = c;
         end
         pos = (i == 1) ? (n - 1 - k) : k;
         w = w | (32'(r) << (pos * sl));
      end
      return w;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_data[i]  = 32'h0;
         m_count[i] = 0;
         m_last[i]  = 1'b0;
         m_nb[i]    = 0;
      end
   endfunction

   function automatic void model_step(int i, bit v, logic [7:0] d, bit l, bit r);
      int  n;
      bit  hs;
      bit  take;
      n    = 32 / sl_of(i);
      hs   = m_valid[i] && r;
      take = v && (!m_valid[i] || r);
      if (take) begin
         m_buf[i][m_nb[i]] = (sl_of(i) == 8) ? d : (d & 8'h01);
         m_nb[i]++;
         if (m_nb[i] == n || l) begin
            m_data[i]  = build_word(i);
            m_count[i] = m_nb[i];
            m_last[i]  = l;
            m_valid[i] = 1'b1;
            m_nb[i]    = 0;
         end else if (hs) begin
            m_valid[i] = 1'b0;
         end
      end else if (hs) begin
         m_valid[i] = 1'b0;
      end
   endfunction

   task automatic check_outputs();
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(m_valid[i]));
         check_val($sformatf("out_data%0d", i), od[i], m_data[i]);
         check_val($sformatf("out_count%0d", i), 32'(oc[i]), 32'(m_count[i]));
         check_val($sformatf("out_last%0d", i), 32'(ol[i]), 32'(m_last[i]));
      end
   endtask

   // one clock: drive at negedge, check in_ready, advance model, check after posedge
   task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r);
      @(negedge clk);
      rst = 1'b0;
      in_valid = v;
      in_data = d;
      in_last = l;
      out_ready = r;
      #1;
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(!m_valid[i] || r));
         model_step(i, v, d, l, r);
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      in_last = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      model_reset();
      check_outputs();
   endtask

   initial begin
      logic [31:0] word;
      model_reset();

      // word-order basics
      do_reset();
      step(1'b1, 8'h67, 1'b0, 1'b1);
      step(1'b1, 8'h45, 1'b0, 1'b1);
      step(1'b1, 8'h23, 1'b0, 1'b1);
      step(1'b1, 8'h01, 1'b0, 1'b1);
      check_val("lsb_valid", 32'(ov[0]), 32'h1);
      check_val("lsb_word", od[0], 32'h01234567);
      check_val("lsb_count", 32'(oc[0]), 32'h4);
      check_val("lsb_last", 32'(ol[0]), 32'h0);

      do_reset();
      step(1'b1, 8'h01, 1'b0, 1'b1);
      step(1'b1, 8'h23, 1'b0, 1'b1);
      step(1'b1, 8'h45, 1'b0, 1'b1);
      step(1'b1, 8'h67, 1'b0, 1'b1);
      check_val("msb_word", od[1], 32'h01234567);

      // single-bit slices fed MSB first give the bit-reversed word
      do_reset();
      word = 32'h89abcdef;
      for (int k = 31; k >= 0; k--) step(1'b1, {7'h00, word[k]}, 1'b0, 1'b1);
      check_val("bitrev_word", od[2], 32'hf7b3d591);
      check_val("bitrev_count", 32'(oc[2]), 32'd32);

      // early termination, then a fresh word starting at slot 0
      do_reset();
      step(1'b1, 8'hAA, 1'b0, 1'b1);
      step(1'b1, 8'hBB, 1'b1, 1'b1);
      check_val("part_word", od[0], 32'h0000BBAA);
      check_val("part_count", 32'(oc[0]), 32'h2);
      check_val("part_last", 32'(ol[0]), 32'h1);
      step(1'b1, 8'h11, 1'b0, 1'b1);
      step(1'b1, 8'h22, 1'b0, 1'b1);
      step(1'b1, 8'h33, 1'b0, 1'b1);
      step(1'b1, 8'h44, 1'b0, 1'b1);
      check_val("after_part", od[0], 32'h44332211);

      // backpressure: held word, in_ready low, then release with a chunk pending
      do_reset();
      step(1'b1, 8'h67, 1'b0, 1'b1);
      step(1'b1, 8'h45, 1'b0, 1'b1);
      step(1'b1, 8'h23, 1'b0, 1'b1);
      step(1'b1, 8'h01, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step(1'b1, 8'($urandom), 1'b0, 1'b0);
         check_val("bp_ready", 32'(rdy[0]), 32'h0);
         check_val("bp_hold", od[0], 32'h01234567);
      end
      step(1'b1, 8'h55, 1'b0, 1'b1);
      check_val("bp_drain", 32'(ov[0]), 32'h0);
      step(1'b1, 8'h66, 1'b0, 1'b1);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      step(1'b1, 8'h88, 1'b0, 1'b1);
      check_val("bp_release", od[0], 32'h88776655);

      // two words back to back without a bubble
      do_reset();
      for (int c = 0; c < 8; c++) begin
         step(1'b1, 8'(c), 1'b0, 1'b1);
         check_val("stream_ready", 32'(rdy[0]), 32'h1);
         if (c == 3) check_val("stream_w0", od[0], 32'h03020100);
      end
      check_val("stream_w1", od[0], 32'h07060504);
      check_val("stream_v1", 32'(ov[0]), 32'h1);

      // reset discards a partial word
      do_reset();
      step(1'b1, 8'hC3, 1'b0, 1'b1);
      step(1'b1, 8'h5A, 1'b0, 1'b1);
      do_reset();
      step(1'b1, 8'h11, 1'b0, 1'b1);
      step(1'b1, 8'h22, 1'b0, 1'b1);
      step(1'b1, 8'h33, 1'b0, 1'b1);
      step(1'b1, 8'h44, 1'b0, 1'b1);
      check_val("rst_mid_word", od[0], 32'h44332211);

      // in-chunk bit reversal
      do_reset();
      step(1'b1, 8'h01, 1'b0, 1'b1);
      step(1'b1, 8'h02, 1'b0, 1'b1);
      step(1'b1, 8'h04, 1'b0, 1'b1);
      step(1'b1, 8'h08, 1'b0, 1'b1);
      check_val("brev_word", od[3], 32'h10204080);

      // randomized traffic with idles, early lasts, stalls and occasional resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
